mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Multiply-accumulate back end for the 4-bit ALU datapath. It sits directly downstream of the 4x4 array multiplier and consumes its 8-bit product. It sums a fixed-length run of products (a dot product) into a wide accumulator and presents the finished sum through a valid/ready handshake. A sticky overflow flag reports any wrap of the accumulator.

## Interface
Parameters:
- ACC_W, 12, accumulator and result width in bits; must be ≥ 8.
- DOT_LEN, 4, number of products summed per result; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous abort; discards the partial sum and returns the block to IDLE.
- p  in  8  unsigned product from the multiplier.
- in_valid  in  1  p holds a product to be accumulated.
- in_ready  out  1  block accepts p this cycle.
- acc  out  ACC_W  running sum, or final sum while out_valid is high.
- ovf  out  1  sticky; set when any addition in the current run wraps past 2^ACC_W.
- out_valid  out  1  acc holds a completed DOT_LEN-term sum.
- out_ready  in  1  consumer takes the result.

## Operation
- States:
  - IDLE: no run in progress.
  - ACCUM: partial sum held; beat counter cnt = number of terms accepted.
  - DONE: result presented.
- A beat is accepted when in_valid && in_ready.
- in_ready = (state != DONE). The combinational path is from state only; there is no path from in_valid.
- IDLE, on beat:
  - acc ← zero-extended p (load, not add); ovf ← 0; cnt ← 1.
  - Next state is DONE if DOT_LEN == 1, otherwise ACCUM.
- ACCUM, on beat:
  - {carry, acc} ← acc + zero-extended p; ovf ← ovf | carry; cnt ← cnt + 1.
  - When the new cnt equals DOT_LEN, go to DONE.
- ACCUM, no beat: everything holds. Gaps between beats are unbounded.
- DONE:
  - out_valid = 1; acc and ovf hold.
  - When out_ready is high, go to IDLE.
  - acc and ovf keep the last result in IDLE until the next run's first beat.
- Arithmetic is unsigned modulo 2^ACC_W. Overflow wraps and is never saturated.
- Default sizing: the worst case is 4 × 225 = 900 < 4096, so ovf stays 0.
- clr:
  - In any state: acc ← 0, ovf ← 0, cnt ← 0, state ← IDLE.
  - clr has priority over a beat and over out_ready in the same cycle.
  - A beat presented in the clr cycle is dropped, not accepted.
- The counter width is clog2(DOT_LEN+1). cnt never exceeds DOT_LEN.

## Timing
- Reset values: state IDLE, acc 0, ovf 0, cnt 0, out_valid 0, in_ready 1.
- rst mid-run behaves like clr. rst has priority over clr.
- Accumulate throughput is one beat per cycle.
- out_valid rises on the cycle after the DOT_LEN-th beat is accepted.
- Minimum run length is DOT_LEN cycles of beats plus 1 cycle in DONE (out_ready held high).
- in_ready is low for every cycle spent in DONE.
  - It returns high the cycle after the out_ready handshake.
  - A new run's first beat cannot be accepted in the handshake cycle itself.
- Every output is driven from a register or is a decode of state. There is no input-to-output combinational path.

## Structure
- Shared ALU package holds:
  - the state enum (IDLE, ACCUM, DONE);
  - the product width constant PROD_W = 8;
  - the default ACC_W and DOT_LEN values.
- One sub-module is natural: mac_beat_counter, a clear/increment/terminal-count counter parameterised on DOT_LEN, with output tc = (cnt + 1 == DOT_LEN) on increment.
- The adder, overflow logic and FSM stay in the top module.

## Test plan
- Reset then a 4-beat run:
  - Stimulus: rst pulse, then p = 3, 5, 7, 9 on consecutive cycles with out_ready = 1.
  - Response: after reset, acc = 0, in_ready = 1, out_valid = 0. After the run, out_valid high for exactly 1 cycle with acc = 24 and ovf = 0. in_ready low in that cycle.
- Worst-case default run:
  - Stimulus: four beats of p = 225.
  - Response: acc = 900, ovf = 0.
- Overflow with ACC_W = 8, DOT_LEN = 2:
  - Stimulus: p = 200, 100.
  - Response: acc = 44, ovf = 1. The next run's first beat (p = 1) clears ovf to 0.
- Gapped input and back-pressure:
  - Stimulus: beats p = 1, 2, 3, 4 with 2-cycle in_valid gaps; out_ready held low for 5 cycles after the run.
  - Response: acc = 10 and out_valid stay stable while out_ready is low, in_ready stays 0, and extra in_valid pulses are not absorbed.
- Abort mid-run:
  - Stimulus: after 2 beats (p = 8, 8), assert clr together with in_valid (p = 50).
  - Response: next cycle acc = 0, state IDLE, and the p = 50 beat is dropped. A fresh run of four p = 1 yields acc = 4.
- DOT_LEN = 1:
  - Stimulus: a single beat p = 77.
  - Response: out_valid high the next cycle with acc = 77.

Source files
------------

// File: rtl/mac_accumulator_pkg.sv
// Shared ALU datapath definitions: the MAC state encoding, the product width and the default
// accumulator sizing.
package mac_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } macState_t;

   localparam int PROD_W      = 8;
   localparam int DEF_ACC_W   = 12;
   localparam int DEF_DOT_LEN = 4;

endpackage

// File: rtl/mac_beat_counter.sv
// Counts accepted beats of one run. tc is combinational on inc and marks the DOT_LEN-th beat.
// No backpressure of its own: the owner gates inc and clears the count between runs.
module mac_beat_counter
   import mac_accumulator_pkg::*;
#(
   parameter int DOT_LEN = DEF_DOT_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   localparam int CNT_W = $clog2(DOT_LEN + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // One extra bit so cnt+1 cannot wrap before the compare.
   assign tc = inc && (({1'b0, cnt} + (CNT_W + 1)'(1)) == (CNT_W + 1)'(DOT_LEN));

endmodule

// File: rtl/mac_accumulator.sv
// Sums DOT_LEN unsigned products into an ACC_W-bit result with a sticky wrap flag; out_valid
// rises the cycle after the last beat, and in_ready stays low until the result is taken.
module mac_accumulator
   import mac_accumulator_pkg::*;
#(
   parameter int ACC_W   = DEF_ACC_W,
   parameter int DOT_LEN = DEF_DOT_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [PROD_W-1:0] p,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf,
   output logic              out_valid,
   input  logic              out_ready
);

   macState_t        state;
   logic [ACC_W-1:0] accQ;
   logic             ovfQ;
   logic             beat;
   logic             lastBeat;
   logic [ACC_W:0]   sum;

   assign in_ready  = (state != DONE);
   assign out_valid = (state == DONE);
   assign acc       = accQ;
   assign ovf       = ovfQ;

   // A beat offered alongside clr is dropped, so it must not advance the count either.
   assign beat = in_valid && in_ready && !clr;
   assign sum  = {1'b0, accQ} + (ACC_W + 1)'(p);

   mac_beat_counter #(
      .DOT_LEN(DOT_LEN)
   ) uBeatCounter (
      .clk(clk),
      .rst(rst),
      .clr(clr || (out_valid && out_ready)),
      .inc(beat),
      .tc (lastBeat)
   );

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state <= IDLE;
         accQ  <= '0;
         ovfQ  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (beat) begin
                  accQ  <= ACC_W'(p);
                  ovfQ  <= 1'b0;
                  state <= lastBeat ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (beat) begin
                  accQ <= sum[ACC_W-1:0];
                  ovfQ <= ovfQ | sum[ACC_W];
                  if (lastBeat) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a vector table on the default sizing plus short
// sequences on an 8-bit/2-term instance and a single-term instance.
module tb_mac_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Default instance: ACC_W = 12, DOT_LEN = 4
   logic        clrA = 1'b0, vldA = 1'b0, ordyA = 1'b0, irdyA, ovfA, ovldA;
   logic [7:0]  pA = '0;
   logic [11:0] accA;

   // ACC_W = 8, DOT_LEN = 2
   logic        clrB = 1'b0, vldB = 1'b0, ordyB = 1'b0, irdyB, ovfB, ovldB;
   logic [7:0]  pB = '0;
   logic [7:0]  accB;

   // DOT_LEN = 1
   logic        clrC = 1'b0, vldC = 1'b0, ordyC = 1'b0, irdyC, ovfC, ovldC;
   logic [7:0]  pC = '0;
   logic [11:0] accC;

   mac_accumulator dutA (
      .clk(clk), .rst(rst), .clr(clrA), .p(pA), .in_valid(vldA), .in_ready(irdyA),
      .acc(accA), .ovf(ovfA), .out_valid(ovldA), .out_ready(ordyA)
   );

   mac_accumulator #(.ACC_W(8), .DOT_LEN(2)) dutB (
      .clk(clk), .rst(rst), .clr(clrB), .p(pB), .in_valid(vldB), .in_ready(irdyB),
      .acc(accB), .ovf(ovfB), .out_valid(ovldB), .out_ready(ordyB)
   );

   mac_accumulator #(.ACC_W(12), .DOT_LEN(1)) dutC (
      .clk(clk), .rst(rst), .clr(clrC), .p(pC), .in_valid(vldC), .in_ready(irdyC),
      .acc(accC), .ovf(ovfC), .out_valid(ovldC), .out_ready(ordyC)
   );

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chkA(input string tag, input int eAcc, input int eOvf, input int eOvld,
                       input int eIrdy);
      chk({tag, " acc"}, int'(accA), eAcc);
      chk({tag, " ovf"}, int'(ovfA), eOvf);
      chk({tag, " out_valid"}, int'(ovldA), eOvld);
      chk({tag, " in_ready"}, int'(irdyA), eIrdy);
   endtask

   // Each record: inputs held for one clock, expected outputs just after that edge.
   typedef struct {
      logic       clr;
      logic       vld;
      logic [7:0] p;
      logic       ordy;
      int         acc;
      int         ovf;
      int         ovld;
      int         irdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic c, input logic v, input int pp, input logic o,
                               input int a, input int f, input int ov, input int ir);
      vec_t r;
      r.clr = c; r.vld = v; r.p = 8'(pp); r.ordy = o;
      r.acc = a; r.ovf = f; r.ovld = ov; r.irdy = ir;
      return r;
   endfunction

   task automatic stepAll();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 4-beat run 3+5+7+9 with out_ready high: result visible for exactly one cycle
      vecs.push_back(mk(0, 1, 3,   1, 3,   0, 0, 1));
      vecs.push_back(mk(0, 1, 5,   1, 8,   0, 0, 1));
      vecs.push_back(mk(0, 1, 7,   1, 15,  0, 0, 1));
      vecs.push_back(mk(0, 1, 9,   1, 24,  0, 1, 0));
      vecs.push_back(mk(0, 0, 0,   1, 24,  0, 0, 1));
      // Worst-case default run: 4 x 225 = 900, no wrap
      vecs.push_back(mk(0, 1, 225, 1, 225, 0, 0, 1));
      vecs.push_back(mk(0, 1, 225, 1, 450, 0, 0, 1));
      vecs.push_back(mk(0, 1, 225, 1, 675, 0, 0, 1));
      vecs.push_back(mk(0, 1, 225, 1, 900, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,   1, 900, 0, 0, 1));
      // Gapped beats 1,2,3,4 with out_ready low
      vecs.push_back(mk(0, 1, 1,   0, 1,   0, 0, 1));
      vecs.push_back(mk(0, 0, 0,   0, 1,   0, 0, 1));
      vecs.push_back(mk(0, 0, 0,   0, 1,   0, 0, 1));
      vecs.push_back(mk(0, 1, 2,   0, 3,   0, 0, 1));
      vecs.push_back(mk(0, 0, 0,   0, 3,   0, 0, 1));
      vecs.push_back(mk(0, 0, 0,   0, 3,   0, 0, 1));
      vecs.push_back(mk(0, 1, 3,   0, 6,   0, 0, 1));
      vecs.push_back(mk(0, 0, 0,   0, 6,   0, 0, 1));
      vecs.push_back(mk(0, 0, 0,   0, 6,   0, 0, 1));
      vecs.push_back(mk(0, 1, 4,   0, 10,  0, 1, 0));
      // Held result under back-pressure; extra in_valid pulses must not be absorbed
      for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 99, 0, 10, 0, 1, 0));
      // Handshake cycle: the beat offered here is still refused
      vecs.push_back(mk(0, 1, 99,  1, 10,  0, 0, 1));
      vecs.push_back(mk(0, 0, 0,   0, 10,  0, 0, 1));
      // Abort: 8, 8, then clr together with a p=50 beat
      vecs.push_back(mk(0, 1, 8,   0, 8,   0, 0, 1));
      vecs.push_back(mk(0, 1, 8,   0, 16,  0, 0, 1));
      vecs.push_back(mk(1, 1, 50,  0, 0,   0, 0, 1));
      vecs.push_back(mk(0, 1, 1,   0, 1,   0, 0, 1));
      vecs.push_back(mk(0, 1, 1,   0, 2,   0, 0, 1));
      vecs.push_back(mk(0, 1, 1,   0, 3,   0, 0, 1));
      vecs.push_back(mk(0, 1, 1,   0, 4,   0, 1, 0));
      // clr beats out_ready in DONE
      vecs.push_back(mk(1, 0, 0,   1, 0,   0, 0, 1));

      // Reset
      stepAll();
      stepAll();
      rst = 1'b0;
      chkA("reset", 0, 0, 0, 1);
      chk("reset B acc", int'(accB), 0);
      chk("reset C out_valid", int'(ovldC), 0);

      foreach (vecs[i]) begin
         clrA  = vecs[i].clr;
         vldA  = vecs[i].vld;
         pA    = vecs[i].p;
         ordyA = vecs[i].ordy;
         stepAll();
         chkA($sformatf("vec%0d", i), vecs[i].acc, vecs[i].ovf, vecs[i].ovld, vecs[i].irdy);
      end
      clrA = 1'b0; vldA = 1'b0; ordyA = 1'b0;

      // Overflow on the 8-bit instance: 200 + 100 = 300 wraps to 44
      vldB = 1'b1; pB = 8'd200; ordyB = 1'b0;
      stepAll();
      chk("ovfB first acc", int'(accB), 200);
      pB = 8'd100;
      stepAll();
      chk("ovfB wrap acc", int'(accB), 44);
      chk("ovfB flag", int'(ovfB), 1);
      chk("ovfB out_valid", int'(ovldB), 1);
      vldB = 1'b0; ordyB = 1'b1;
      stepAll();
      chk("ovfB held in IDLE", int'(ovfB), 1);
      chk("ovfB idle in_ready", int'(irdyB), 1);
      vldB = 1'b1; pB = 8'd1; ordyB = 1'b0;
      stepAll();
      chk("ovfB new run acc", int'(accB), 1);
      chk("ovfB new run flag", int'(ovfB), 0);
      vldB = 1'b0;

      // Single-term instance
      vldC = 1'b1; pC = 8'd77; ordyC = 1'b0;
      stepAll();
      chk("len1 acc", int'(accC), 77);
      chk("len1 out_valid", int'(ovldC), 1);
      chk("len1 in_ready", int'(irdyC), 0);
      vldC = 1'b0; ordyC = 1'b1;
      stepAll();
      chk("len1 released", int'(ovldC), 0);

      // rst mid-run on the default instance
      vldA = 1'b1; pA = 8'd40;
      stepAll();
      stepAll();
      chk("pre-rst acc", int'(accA), 80);
      rst = 1'b1; vldA = 1'b0;
      stepAll();
      rst = 1'b0;
      chkA("mid-run rst", 0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
